// File: rtl/sev_seg_number_formatter.sv
// Converts a 16-bit value to four seven-segment digit patterns, in decimal or hex.
// Decimal conversion uses a 16-step double-dabble. Hex mode uses the same latency.
module sev_seg_number_formatter #(
    parameter bit BLANK_LEADING_ZEROS = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        hex_mode,
    input  logic [15:0] value,
    input  logic [3:0]  dots_in,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic [6:0]  digit_0,
    output logic [6:0]  digit_1,
    output logic [6:0]  digit_2,
    output logic [6:0]  digit_3,
    output logic [3:0]  dots
);

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        ENCODE
    } state_t;

    state_t      r_state;
    logic [15:0] r_value;
    logic        r_hex;
    logic [3:0]  r_dotsCap;
    logic [19:0] r_bcd;
    logic [15:0] r_shift;
    logic [4:0]  r_count;
    logic        r_busy;
    logic        r_done;
    logic        r_overflow;
    logic [6:0]  r_digit [4];
    logic [3:0]  r_dots;

    logic [19:0] w_adj;
    logic [19:0] w_nextBcd;
    logic [15:0] w_nextShift;
    logic [3:0]  w_nib [4];
    logic        w_ovf;
    logic [3:0]  w_blank;
    logic [6:0]  w_digit [4];

    function automatic logic [6:0] segEncode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // One double-dabble step: add 3 to nibbles >= 5, then shift {bcd, shift} left.
    always_comb begin
        w_adj = '0;
        for (int i = 0; i < 5; i++) begin
            w_adj[4*i +: 4] = (r_bcd[4*i +: 4] >= 4'd5) ? r_bcd[4*i +: 4] + 4'd3
                                                        : r_bcd[4*i +: 4];
        end
        w_nextBcd   = {w_adj[18:0], r_shift[15]};
        w_nextShift = {r_shift[14:0], 1'b0};
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_nib[i] = r_hex ? r_value[4*i +: 4] : r_bcd[4*i +: 4];
        end
        w_ovf = !r_hex && ((r_bcd[19:16] != 4'd0) || (r_value > 16'd9999));

        w_blank    = 4'b0000;
        w_blank[3] = BLANK_LEADING_ZEROS && (w_nib[3] == 4'd0);
        w_blank[2] = w_blank[3] && (w_nib[2] == 4'd0);
        w_blank[1] = w_blank[2] && (w_nib[1] == 4'd0);

        for (int i = 0; i < 4; i++) begin
            if (w_ovf) begin
                w_digit[i] = 7'h40;
            end else if (w_blank[i]) begin
                w_digit[i] = 7'h00;
            end else begin
                w_digit[i] = segEncode(w_nib[i]);
            end
        end
    end

    // Outputs are only updated on the ENCODE edge and hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_value    <= '0;
            r_hex      <= 1'b0;
            r_dotsCap  <= '0;
            r_bcd      <= '0;
            r_shift    <= '0;
            r_count    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            r_dots     <= '0;
            for (int i = 0; i < 4; i++) begin
                r_digit[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_value   <= value;
                        r_hex     <= hex_mode;
                        r_dotsCap <= dots_in;
                        r_bcd     <= '0;
                        r_shift   <= value;
                        r_count   <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= CONVERT;
                    end
                end
                CONVERT: begin
                    r_bcd   <= w_nextBcd;
                    r_shift <= w_nextShift;
                    r_count <= r_count + 5'd1;
                    if (r_count == 5'd15) begin
                        r_state <= ENCODE;
                    end
                end
                ENCODE: begin
                    for (int i = 0; i < 4; i++) begin
                        r_digit[i] <= w_digit[i];
                    end
                    r_dots     <= r_dotsCap;
                    r_overflow <= w_ovf;
                    r_done     <= 1'b1;
                    r_busy     <= 1'b0;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign overflow = r_overflow;
    assign digit_0  = r_digit[0];
    assign digit_1  = r_digit[1];
    assign digit_2  = r_digit[2];
    assign digit_3  = r_digit[3];
    assign dots     = r_dots;

endmodule

// File: tb/tb_sev_seg_number_formatter.sv
// Self-checking bench for sev_seg_number_formatter: a constant vector table, hand-written
// corner sequences and random conversions compared against an arithmetic reference model.
module tb_sev_seg_number_formatter;

   logic        clock = 1'b0;
   logic        rst;
   logic        start;
   logic        hexMode;
   logic [15:0] value;
   logic [3:0]  dotsIn;

   logic        busyA, doneA, ovfA;
   logic [6:0]  a0, a1, a2, a3;
   logic [3:0]  dotsA;
   logic        busyB, doneB, ovfB;
   logic [6:0]  b0, b1, b2, b3;
   logic [3:0]  dotsB;

   int checkCount = 0;
   int passCount  = 0;

   sev_seg_number_formatter #(.BLANK_LEADING_ZEROS(1'b1)) dutBlank (
      .clk(clock), .rst(rst), .start(start), .hex_mode(hexMode), .value(value),
      .dots_in(dotsIn), .busy(busyA), .done(doneA), .overflow(ovfA),
      .digit_0(a0), .digit_1(a1), .digit_2(a2), .digit_3(a3), .dots(dotsA)
   );

   sev_seg_number_formatter #(.BLANK_LEADING_ZEROS(1'b0)) dutNoBlank (
      .clk(clock), .rst(rst), .start(start), .hex_mode(hexMode), .value(value),
      .dots_in(dotsIn), .busy(busyB), .done(doneB), .overflow(ovfB),
      .digit_0(b0), .digit_1(b1), .digit_2(b2), .digit_3(b3), .dots(dotsB)
   );

   // 100 MHz clock
   always #5 clock = ~clock;

   // Hard stop in case something never terminates
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected finish earlier");
      $fatal(1, "[TB] watchdog expired");
   end

   typedef struct {
      logic        hexM;
      logic [15:0] v;
      logic [3:0]  dts;
      logic [27:0] expBlank;
      logic [27:0] expNoBlank;
      logic        expOvf;
   } vec_t;

   vec_t vecs[10];

   // Compares one value and keeps the running tallies
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Reference segment pattern for one hex digit
   function automatic logic [6:0] segOf(input int n);
      logic [6:0] tbl [16];
      tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
      return tbl[n];
   endfunction

   // Reference digits {d3,d2,d1,d0} computed with plain division / shifting
   function automatic logic [27:0] modelDigits(input logic hexM, input logic [15:0] v, input bit blankOn);
      int         val;
      int         nib [4];
      int         p10 [4];
      bit         lead;
      logic [6:0] d [4];
      val = v;
      p10 = '{1, 10, 100, 1000};
      for (int i = 0; i < 4; i++) begin
         nib[i] = hexM ? ((val >> (4 * i)) & 15) : ((val / p10[i]) % 10);
      end
      if (!hexM && val > 9999) begin
         for (int i = 0; i < 4; i++) d[i] = 7'h40;
      end else begin
         lead = 1'b1;
         for (int i = 3; i >= 1; i--) begin
            if (nib[i] != 0) lead = 1'b0;
            d[i] = (blankOn && lead) ? 7'h00 : segOf(nib[i]);
         end
         d[0] = segOf(nib[0]);
      end
      return {d[3], d[2], d[1], d[0]};
   endfunction

   // Pulses start for one edge, then waits for done and checks latency, busy length and hold
   task automatic applyStimulus(input logic hexM, input logic [15:0] v, input logic [3:0] dts, input string tag);
      logic [27:0] prevA;
      int n;
      int busyCount;
      int changes;
      hexMode = hexM;
      value   = v;
      dotsIn  = dts;
      start   = 1'b1;
      @(posedge clock);
      #1;
      start     = 1'b0;
      hexMode   = ~hexM;
      value     = 16'($urandom);
      dotsIn    = ~dts;
      prevA     = {a3, a2, a1, a0};
      busyCount = busyA ? 1 : 0;
      changes   = 0;
      for (n = 1; n <= 40; n++) begin
         @(posedge clock);
         #1;
         if (doneA) break;
         if (busyA) busyCount++;
         if ({a3, a2, a1, a0} !== prevA) changes++;
      end
      checkOutput({tag, " done latency"}, n, 17);
      checkOutput({tag, " busy cycles"}, busyCount, 17);
      checkOutput({tag, " hold during convert"}, changes, 0);
      checkOutput({tag, " busy low at done"}, 32'(busyA), 0);
   endtask

   initial begin
      logic        hexM;
      logic [15:0] v;
      logic [3:0]  dts;
      int          doneCount;

      vecs[0] = '{1'b0, 16'd1234,  4'b0100, {7'h06, 7'h5B, 7'h4F, 7'h66}, {7'h06, 7'h5B, 7'h4F, 7'h66}, 1'b0};
      vecs[1] = '{1'b0, 16'd7,     4'b0000, {7'h00, 7'h00, 7'h00, 7'h07}, {7'h3F, 7'h3F, 7'h3F, 7'h07}, 1'b0};
      vecs[2] = '{1'b0, 16'd0,     4'b1111, {7'h00, 7'h00, 7'h00, 7'h3F}, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 1'b0};
      vecs[3] = '{1'b0, 16'd1005,  4'b0001, {7'h06, 7'h3F, 7'h3F, 7'h6D}, {7'h06, 7'h3F, 7'h3F, 7'h6D}, 1'b0};
      vecs[4] = '{1'b0, 16'd10000, 4'b1000, {7'h40, 7'h40, 7'h40, 7'h40}, {7'h40, 7'h40, 7'h40, 7'h40}, 1'b1};
      vecs[5] = '{1'b0, 16'd65535, 4'b0010, {7'h40, 7'h40, 7'h40, 7'h40}, {7'h40, 7'h40, 7'h40, 7'h40}, 1'b1};
      vecs[6] = '{1'b0, 16'd9999,  4'b1010, {7'h6F, 7'h6F, 7'h6F, 7'h6F}, {7'h6F, 7'h6F, 7'h6F, 7'h6F}, 1'b0};
      vecs[7] = '{1'b1, 16'hBEEF,  4'b0101, {7'h7C, 7'h79, 7'h79, 7'h71}, {7'h7C, 7'h79, 7'h79, 7'h71}, 1'b0};
      vecs[8] = '{1'b1, 16'h00A5,  4'b0011, {7'h00, 7'h00, 7'h77, 7'h6D}, {7'h3F, 7'h3F, 7'h77, 7'h6D}, 1'b0};
      vecs[9] = '{1'b1, 16'hFFFF,  4'b1100, {7'h71, 7'h71, 7'h71, 7'h71}, {7'h71, 7'h71, 7'h71, 7'h71}, 1'b0};

      // Reset with start held high at the same time
      rst     = 1'b1;
      start   = 1'b1;
      hexMode = 1'b0;
      value   = 16'd1234;
      dotsIn  = 4'hF;
      repeat (2) @(posedge clock);
      #1;
      checkOutput("reset digits", {4'h0, a3, a2, a1, a0}, 32'h0);
      checkOutput("reset flags", {busyA, doneA, ovfA}, 3'b000);
      checkOutput("reset dots", 32'(dotsA), 0);
      rst   = 1'b0;
      start = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      checkOutput("start during reset ignored", 32'(busyA), 0);

      // Constant table; conversions run back to back
      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i].hexM, vecs[i].v, vecs[i].dts, $sformatf("vec%0d", i));
         checkOutput($sformatf("vec%0d digits", i), {4'h0, a3, a2, a1, a0}, {4'h0, vecs[i].expBlank});
         checkOutput($sformatf("vec%0d noblank digits", i), {4'h0, b3, b2, b1, b0}, {4'h0, vecs[i].expNoBlank});
         checkOutput($sformatf("vec%0d overflow", i), 32'(ovfA), 32'(vecs[i].expOvf));
         checkOutput($sformatf("vec%0d dots", i), 32'(dotsA), 32'(vecs[i].dts));
      end

      // done must fall after exactly one cycle
      @(posedge clock);
      #1;
      checkOutput("done one cycle", 32'(doneA), 0);

      // Hex BEEF with a second start at E5 that must be ignored
      hexMode = 1'b1;
      value   = 16'hBEEF;
      dotsIn  = 4'b1001;
      start   = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clock);
      #1;
      value   = 16'h1111;
      dotsIn  = 4'b0110;
      start   = 1'b1;
      @(posedge clock);
      #1;
      start     = 1'b0;
      doneCount = 0;
      repeat (40) begin
         @(posedge clock);
         #1;
         if (doneA) doneCount++;
      end
      checkOutput("beef done count", doneCount, 1);
      checkOutput("beef digits", {4'h0, a3, a2, a1, a0}, {4'h0, 7'h7C, 7'h79, 7'h79, 7'h71});
      checkOutput("beef dots", 32'(dotsA), 32'(4'b1001));
      checkOutput("beef overflow", 32'(ovfA), 0);

      // Reset at E8 of a 4321 conversion aborts it
      hexMode = 1'b0;
      value   = 16'd4321;
      dotsIn  = 4'b1111;
      start   = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      repeat (7) @(posedge clock);
      #1;
      rst = 1'b1;
      @(posedge clock);
      #1;
      rst = 1'b0;
      checkOutput("abort digits", {4'h0, a3, a2, a1, a0}, 32'h0);
      checkOutput("abort flags", {busyA, doneA, ovfA}, 3'b000);
      checkOutput("abort dots", 32'(dotsA), 0);
      doneCount = 0;
      repeat (25) begin
         @(posedge clock);
         #1;
         if (doneA) doneCount++;
      end
      checkOutput("abort no done", doneCount, 0);
      applyStimulus(1'b0, 16'd42, 4'b0000, "after abort");
      checkOutput("after abort digits", {4'h0, a3, a2, a1, a0}, {4'h0, 7'h00, 7'h00, 7'h66, 7'h5B});
      checkOutput("after abort overflow", 32'(ovfA), 0);

      // Random conversions against the reference model
      for (int k = 0; k < 40; k++) begin
         hexM = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 3))
            0:       v = 16'($urandom_range(0, 65535));
            1:       v = 16'($urandom_range(0, 120));
            default: v = 16'($urandom_range(0, 12000));
         endcase
         dts = 4'($urandom);
         applyStimulus(hexM, v, dts, $sformatf("rand%0d", k));
         checkOutput($sformatf("rand%0d digits v=%0h hex=%0d", k, v, hexM),
                     {4'h0, a3, a2, a1, a0}, {4'h0, modelDigits(hexM, v, 1'b1)});
         checkOutput($sformatf("rand%0d noblank digits v=%0h hex=%0d", k, v, hexM),
                     {4'h0, b3, b2, b1, b0}, {4'h0, modelDigits(hexM, v, 1'b0)});
         checkOutput($sformatf("rand%0d overflow", k), 32'(ovfA), 32'(!hexM && v > 16'd9999));
         checkOutput($sformatf("rand%0d dots", k), 32'(dotsA), 32'(dts));
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/sev_seg_number_formatter.md
# sev_seg_number_formatter

Sequential number-to-segment formatter that feeds the four-digit seven-segment display controller. It accepts a 16-bit value on a start pulse. It converts the value to four decimal digits using iterative double-dabble, or takes four hex nibbles directly. It then encodes each digit into an active-high seven-segment pattern and holds the patterns, plus dots, stable on its outputs until the next conversion completes.

## Interface

Parameters:
- BLANK_LEADING_ZEROS, 1: when 1, leading zero digits 3..1 are output as blank (7'h00); digit 0 is never blanked.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request a conversion; sampled only in IDLE.
- hex_mode  input  1  0 = decimal, 1 = hexadecimal; captured with start.
- value  input  16  number to display; captured with start.
- dots_in  input  4  dot enables, bit i = digit i; captured with start.
- busy  output  1  conversion in progress.
- done  output  1  one-cycle pulse when new outputs are valid.
- overflow  output  1  last decimal conversion had value > 9999.
- digit_0..digit_3  output  7 each  segment patterns {g,f,e,d,c,b,a}, active-high; digit_0 is the rightmost digit.
- dots  output  4  registered dot enables.

Clock and reset: one clock; reset is synchronous and active-high.

## Operation

- States: IDLE, CONVERT, ENCODE.
- IDLE with start=1: capture value, hex_mode and dots_in. Clear the 20-bit BCD accumulator, load the shift register, set the iteration counter to 0, and go to CONVERT.
- CONVERT runs exactly 16 iterations, one per clock.
  - In decimal mode, each iteration first adds 3 to every BCD nibble that is ≥5, then shifts {bcd, shift} left by 1.
  - In hex mode, the iterations still run, but the result is ignored; latency is identical in both modes.
  - After iteration 16, go to ENCODE.
- ENCODE, one cycle, then return to IDLE:
  - Select the nibbles. Decimal uses BCD nibbles 3..0. Hex uses value[15:12]..value[3:0].
  - Decimal overflow: if BCD nibble 4 ≠ 0, or the captured value > 9999, all four digits become 7'h40 ("----") and overflow=1. Otherwise overflow=0. In hex mode, overflow=0.
  - Encode each nibble: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
  - Leading-zero blanking (parameter = 1, not in overflow): digit_3 is blank if nibble 3 = 0. digit_2 is blank if nibbles 3 and 2 are 0. digit_1 is blank if nibbles 3..1 are 0. digit_0 is never blanked.
  - Register digit_0..3, dots (= captured dots_in) and overflow, and pulse done.
- Outputs change only on the ENCODE edge; they hold their old values during CONVERT.
- start while busy is ignored. No queuing, no error flag.
- Arithmetic: the 16-bit input needs 5 BCD nibbles (20 bits). The iteration counter is 5 bits wide and wrap-free (0..16).

## Timing

- Edge E0: start sampled in IDLE.
- Edges E1..E16: the 16 iterations.
- Edge E17: ENCODE registers the outputs.
- busy=1 from after E0 until after E17 (17 cycles).
- done=1 for exactly the cycle after E17.
- Outputs are valid 17 clocks after the start edge.
- A start asserted in the cycle where done=1 is accepted (state is IDLE); back-to-back throughput is one conversion per 18 cycles.
- Reset values: busy=0, done=0, overflow=0, digit_0..3=7'h00, dots=4'h0, state IDLE.
- rst has priority over start. Reset mid-conversion aborts immediately: outputs return to reset values next cycle, and no done is issued.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan

- Reset: hold rst 2 cycles → all outputs 0, busy=0; start asserted together with rst is ignored.
- Decimal 1234, dots_in=4'b0100 → at E17: digit_3..0 = 06,5B,4F,66; dots=4'b0100; overflow=0; done high 1 cycle; busy high exactly 17 cycles.
- Blanking with BLANK_LEADING_ZEROS=1:
  - value 7 → 00,00,00,07.
  - value 0 → 00,00,00,3F.
  - value 1005 → 06,3F,3F,6D.
  - With the parameter at 0, value 7 → 3F,3F,3F,07.
- Decimal 10000 and 65535 → all digits 40, overflow=1. A following decimal 9999 → 6F ×4, overflow=0.
- Hex 0xBEEF → 7C,79,79,71 at E17, overflow=0. A second start at E5 with value 0x1111 is ignored (outputs show BEEF, one done only).
- Reset at E8 of a conversion of 4321 → no done; outputs return to reset values. A subsequent start with 42 completes normally: 00,00,66,5B after 17 cycles.
